// File: rtl/fir_bank_seq.sv
// Time-multiplexed bank of signed FIR/wavelet filters sharing one snapshotted tap window.
// A single MAC walks every (filter, tap) pair, then each filter result is rounded, shifted and saturated.
module fir_bank_seq #(
   parameter int BITS_PER_ELEM = 8,
   parameter int NUM_ELEM      = 7,
   parameter int NUM_FILTERS   = 2,
   parameter int OUT_BITS      = 8,
   parameter int OUT_SHIFT     = 11,
   parameter int ROUND         = 1,
   parameter logic [NUM_FILTERS*NUM_ELEM*BITS_PER_ELEM-1:0] FILTER_VALS = '0,
   localparam int NTOT = NUM_FILTERS * NUM_ELEM,
   localparam int AW   = (NTOT > 1) ? $clog2(NTOT) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_start_calc,
   input  logic [NUM_ELEM*BITS_PER_ELEM-1:0] taps,
   input  logic                              i_coef_we,
   input  logic [AW-1:0]                     i_coef_addr,
   input  logic [BITS_PER_ELEM-1:0]          i_coef_data,
   output logic                              o_busy,
   output logic                              o_valid,
   output logic [NUM_FILTERS*OUT_BITS-1:0]   o_wavelets
);

   localparam int B      = BITS_PER_ELEM;
   localparam int EW     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
   localparam int FW     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam int PROD_W = 2 * B;
   localparam int ACC_W  = 2 * B + $clog2(NUM_ELEM) + 1;
   localparam int RSH    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam int CW     = NTOT * B;
   localparam int WW     = NUM_FILTERS * OUT_BITS;

   localparam logic signed [ACC_W:0] RND_C =
      ((ROUND != 0) && (OUT_SHIFT > 0)) ? ({{ACC_W{1'b0}}, 1'b1} << RSH) : {(ACC_W+1){1'b0}};
   localparam logic signed [ACC_W:0] SAT_MAX_C = (ACC_W+1)'((2**(OUT_BITS-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN_C = (ACC_W+1)'(-(2**(OUT_BITS-1)));

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [EW-1:0]            i_q, i_d;
   logic [FW-1:0]            f_q, f_d;
   logic [AW-1:0]            k_q, k_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [NUM_ELEM*B-1:0]    tap_snap_q, tap_snap_d;
   logic [CW-1:0]            coef_q, coef_d;
   logic [WW-1:0]            stage_q, stage_d;
   logic [WW-1:0]            wav_q, wav_d;
   logic                     busy_q, busy_d;
   logic                     valid_q, valid_d;
   logic                     pend_we_q, pend_we_d;
   logic [AW-1:0]            pend_addr_q, pend_addr_d;
   logic [B-1:0]             pend_data_q, pend_data_d;

   logic [B-1:0]             coef_sel_s;
   logic [B-1:0]             tap_sel_s;
   logic signed [PROD_W-1:0] prod_s;
   logic signed [ACC_W-1:0]  acc_sum_s;
   logic                     wr_ok_s;

   // Round half up (optional), arithmetic shift, then clamp to the signed output range.
   function automatic logic [OUT_BITS-1:0] sat_round(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] r;
      logic signed [ACC_W:0] sh;
      logic [OUT_BITS-1:0]   res;
      r  = $signed({a[ACC_W-1], a}) + RND_C;
      sh = r >>> OUT_SHIFT;
      if (sh > SAT_MAX_C) begin
         res = SAT_MAX_C[OUT_BITS-1:0];
      end else if (sh < SAT_MIN_C) begin
         res = SAT_MIN_C[OUT_BITS-1:0];
      end else begin
         res = sh[OUT_BITS-1:0];
      end
      return res;
   endfunction

   assign coef_sel_s = coef_q[k_q*B +: B];
   assign tap_sel_s  = tap_snap_q[i_q*B +: B];
   assign prod_s     = $signed({{B{coef_sel_s[B-1]}}, coef_sel_s}) * $signed({{B{tap_sel_s[B-1]}}, tap_sel_s});
   assign acc_sum_s  = acc_q + $signed({{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s});
   assign wr_ok_s    = i_coef_we && !busy_q && (int'(i_coef_addr) < NTOT);

   // Next-state logic for the sequencer, MAC datapath and coefficient store.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      f_d         = f_q;
      k_d         = k_q;
      acc_d       = acc_q;
      tap_snap_d  = tap_snap_q;
      coef_d      = coef_q;
      stage_d     = stage_q;
      wav_d       = wav_q;
      busy_d      = busy_q;
      valid_d     = 1'b0;
      pend_we_d   = pend_we_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      case (state_q)
         S_IDLE: begin
            if (i_start_calc) begin
               state_d    = S_MAC;
               busy_d     = 1'b1;
               tap_snap_d = taps;
               acc_d      = '0;
               i_d        = '0;
               f_d        = '0;
               k_d        = '0;
            end else begin
               state_d = S_IDLE;
            end
            // A write landing with the start is parked so this run still sees the old value.
            if (wr_ok_s && i_start_calc) begin
               pend_we_d   = 1'b1;
               pend_addr_d = i_coef_addr;
               pend_data_d = i_coef_data;
            end else if (wr_ok_s) begin
               coef_d[i_coef_addr*B +: B] = i_coef_data;
            end else begin
               pend_we_d = pend_we_q;
            end
         end
         S_MAC: begin
            acc_d = acc_sum_s;
            k_d   = k_q + AW'(1);
            if (i_q == EW'(NUM_ELEM - 1)) begin
               stage_d[f_q*OUT_BITS +: OUT_BITS] = sat_round(acc_sum_s);
               acc_d = '0;
               i_d   = '0;
               f_d   = f_q + FW'(1);
               if (f_q == FW'(NUM_FILTERS - 1)) begin
                  state_d = S_FINAL;
               end else begin
                  state_d = S_MAC;
               end
            end else begin
               i_d = i_q + EW'(1);
            end
         end
         S_FINAL: begin
            wav_d   = stage_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (pend_we_q) begin
               coef_d[pend_addr_q*B +: B] = pend_data_q;
               pend_we_d = 1'b0;
            end else begin
               pend_we_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any run and restores the default coefficients.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         f_q         <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         tap_snap_q  <= '0;
         coef_q      <= FILTER_VALS;
         stage_q     <= '0;
         wav_q       <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         pend_we_q   <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         f_q         <= f_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         tap_snap_q  <= tap_snap_d;
         coef_q      <= coef_d;
         stage_q     <= stage_d;
         wav_q       <= wav_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         pend_we_q   <= pend_we_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_valid    = valid_q;
   assign o_wavelets = wav_q;

endmodule

// File: tb/tb_fir_bank_seq.sv
// Directed bench for fir_bank_seq: default, truncating, saturating and 1x1 instances side by side.
module tb_fir_bank_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [55:0] taps;
   logic        coef_we;
   logic [3:0]  coef_addr;
   logic [7:0]  coef_data;
   logic        busy, valid;
   logic [15:0] wav;
   logic        busy_t, valid_t;
   logic [15:0] wav_t;
   logic        busy_s, valid_s;
   logic [15:0] wav_s;
   logic        start_d;
   logic [7:0]  taps_d;
   logic        busy_d, valid_d;
   logic [7:0]  wav_d;

   int checks = 0;
   int errors = 0;

   localparam logic [55:0] T_POS = {7{8'h7F}};
   localparam logic [55:0] T_NEG = {7{8'h80}};

   fir_bank_seq #(.FILTER_VALS({14{8'h7F}})) dut (
      .clk(clk), .rst(rst), .i_start_calc(start), .taps(taps),
      .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
      .o_busy(busy), .o_valid(valid), .o_wavelets(wav));

   fir_bank_seq #(.ROUND(0), .FILTER_VALS({14{8'h7F}})) dut_t (
      .clk(clk), .rst(rst), .i_start_calc(start), .taps(taps),
      .i_coef_we(1'b0), .i_coef_addr(4'd0), .i_coef_data(8'd0),
      .o_busy(busy_t), .o_valid(valid_t), .o_wavelets(wav_t));

   // filter 1 = all 127, filter 0 = all -128
   fir_bank_seq #(.OUT_SHIFT(8), .FILTER_VALS({{7{8'h7F}}, {7{8'h80}}})) dut_s (
      .clk(clk), .rst(rst), .i_start_calc(start), .taps(taps),
      .i_coef_we(1'b0), .i_coef_addr(4'd0), .i_coef_data(8'd0),
      .o_busy(busy_s), .o_valid(valid_s), .o_wavelets(wav_s));

   fir_bank_seq #(.NUM_ELEM(1), .NUM_FILTERS(1), .FILTER_VALS(8'd100)) dut_d (
      .clk(clk), .rst(rst), .i_start_calc(start_d), .taps(taps_d),
      .i_coef_we(1'b0), .i_coef_addr(1'b0), .i_coef_data(8'd0),
      .o_busy(busy_d), .o_valid(valid_d), .o_wavelets(wav_d));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      tick();
      coef_we = 1'b0;
   endtask

   // Starts a run, pokes a start (and optionally a coefficient write) while busy, waits for o_valid.
   task automatic run_calc(input bit busy_wr, output int lat, output int bcnt);
      start = 1'b1;
      tick();
      start = 1'b0;
      coef_we = 1'b0;
      lat = 0;
      bcnt = busy ? 1 : 0;
      while (!valid && lat < 40) begin
         start = (lat == 5);
         if (busy_wr && lat == 3) begin
            coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd0;
         end else begin
            coef_we = 1'b0;
         end
         tick();
         lat++;
         if (busy) bcnt++;
      end
      start = 1'b0;
      coef_we = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; start_d = 1'b0; taps = '0; taps_d = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      tick(); tick();
      checks++;
      if ({busy, valid, wav} !== 18'h0) begin
         errors++; $display("FAIL reset_main: got %h expected 0", {busy, valid, wav});
      end
      checks++;
      if ({busy_d, valid_d, wav_d, busy_s, wav_s} !== 27'h0) begin
         errors++; $display("FAIL reset_others: got %h expected 0", {busy_d, valid_d, wav_d, busy_s, wav_s});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic;
      int lat, bcnt;
      taps = T_POS;
      run_calc(1'b0, lat, bcnt);
      checks++;
      if (lat !== 15) begin errors++; $display("FAIL latency: got %0d expected 15", lat); end
      checks++;
      if (bcnt !== 15) begin errors++; $display("FAIL busy_cycles: got %0d expected 15", bcnt); end
      checks++;
      if (wav !== 16'h3737 || busy !== 1'b0) begin
         errors++; $display("FAIL pos_round: got %h busy %b expected 3737 busy 0", wav, busy);
      end
      checks++;
      if (wav_t !== 16'h3737) begin errors++; $display("FAIL pos_trunc: got %h expected 3737", wav_t); end
      checks++;
      if (wav_s !== 16'h7F80) begin errors++; $display("FAIL pos_sat: got %h expected 7f80", wav_s); end
      tick();
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || wav !== 16'h3737) begin
         errors++; $display("FAIL after_valid: got v%b b%b %h expected v0 b0 3737", valid, busy, wav);
      end
   endtask

   task automatic test_negative;
      int lat, bcnt;
      taps = T_NEG;
      run_calc(1'b0, lat, bcnt);
      checks++;
      if (wav !== 16'hC8C8) begin errors++; $display("FAIL neg_round: got %h expected c8c8", wav); end
      checks++;
      if (wav_t !== 16'hC8C8) begin errors++; $display("FAIL neg_trunc: got %h expected c8c8", wav_t); end
      checks++;
      if (wav_s !== 16'h807F) begin errors++; $display("FAIL neg_sat: got %h expected 807f", wav_s); end
   endtask

   task automatic test_back_to_back;
      int e, g;
      taps = T_POS;
      start = 1'b1;
      tick();
      e = 0;
      while (!valid && e < 40) begin
         tick();
         e++;
         if (e == 5) taps = T_NEG;
      end
      checks++;
      if (wav !== 16'h3737 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_first: got %h busy %b expected 3737 busy 0", wav, busy);
      end
      g = 0;
      tick();
      while (!valid && g < 40) begin
         g++;
         tick();
      end
      start = 1'b0;
      // accept edge + 14 MAC edges + FINAL edge leaves 15 idle-output samples between pulses
      checks++;
      if (g !== 15) begin errors++; $display("FAIL b2b_gap: got %0d expected 15", g); end
      checks++;
      if (wav !== 16'hC8C8) begin errors++; $display("FAIL b2b_second: got %h expected c8c8", wav); end
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy %b expected 0", busy); end
   endtask

   task automatic test_coef_write;
      int lat, bcnt;
      for (int a = 7; a < 14; a++) write_coef(4'(a), 8'h00);
      write_coef(4'd15, 8'h00);
      taps = T_POS;
      run_calc(1'b0, lat, bcnt);
      checks++;
      if (wav !== 16'h0037) begin errors++; $display("FAIL coef_idle_write: got %h expected 0037", wav); end
      tick();
      run_calc(1'b1, lat, bcnt);
      checks++;
      if (wav !== 16'h0037) begin errors++; $display("FAIL coef_busy_run: got %h expected 0037", wav); end
      tick();
      run_calc(1'b0, lat, bcnt);
      checks++;
      if (wav !== 16'h0037) begin errors++; $display("FAIL coef_busy_ignored: got %h expected 0037", wav); end
      tick();
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'h00;
      run_calc(1'b0, lat, bcnt);
      checks++;
      if (wav !== 16'h0037) begin errors++; $display("FAIL coef_same_edge_old: got %h expected 0037", wav); end
      tick();
      run_calc(1'b0, lat, bcnt);
      // filter 0 now has six 127 taps: (96774+1024)>>>11 = 47
      checks++;
      if (wav !== 16'h002F) begin errors++; $display("FAIL coef_same_edge_new: got %h expected 002f", wav); end
   endtask

   task automatic test_reset_mid;
      int lat, bcnt, nv;
      taps = T_POS;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, valid, wav} !== 18'h0) begin
         errors++; $display("FAIL reset_async: got %h expected 0", {busy, valid, wav});
      end
      tick();
      rst = 1'b0;
      nv = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (valid || busy) nv++;
      end
      checks++;
      if (nv !== 0) begin errors++; $display("FAIL reset_quiet: got %0d active cycles expected 0", nv); end
      run_calc(1'b0, lat, bcnt);
      checks++;
      if (wav !== 16'h3737) begin errors++; $display("FAIL reset_coef_revert: got %h expected 3737", wav); end
   endtask

   task automatic test_degenerate;
      taps_d = 8'd100;
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
      checks++;
      if (busy_d !== 1'b1 || valid_d !== 1'b0) begin
         errors++; $display("FAIL deg_e0: got b%b v%b expected b1 v0", busy_d, valid_d);
      end
      tick();
      checks++;
      if (valid_d !== 1'b0) begin errors++; $display("FAIL deg_e1: got v%b expected v0", valid_d); end
      tick();
      // (10000+1024)>>>11 = 5
      checks++;
      if (valid_d !== 1'b1 || busy_d !== 1'b0 || wav_d !== 8'd5) begin
         errors++; $display("FAIL deg_e2: got v%b b%b %0d expected v1 b0 5", valid_d, busy_d, wav_d);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      tick();
      test_negative();
      tick();
      test_back_to_back();
      tick();
      test_coef_write();
      tick();
      test_reset_mid();
      tick();
      test_degenerate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
